lcd_text_buffer: RTL and testbench
==================================

Name: lcd_text_buffer

Overview:
- 32-character screen buffer sitting directly upstream of the HD44780 LCD driver; owns the text the driver streams into DD RAM.
- A host (UART decoder, keypad logic, etc.) pushes characters through a valid/ready port; the block interprets a small control-code set and maintains a wrapping cursor.
- The LCD driver indexes the buffer with its 5-bit character counter `sel`. The buffer returns `dd_data` one clock later.

Parameters:
- LINE_LEN, 16, characters per display line; buffer depth is 2*LINE_LEN = 32, fixed by the 5-bit `sel`.
- FILL_CHAR, 8'h20, code written by clear and backspace (ASCII space).

Ports:
- clk  input  1  system clock (50 MHz)
- rst  input  1  asynchronous, active-high reset
- wr_valid  input  1  host presents wr_char
- wr_char  input  8  character or control code
- wr_ready  output  1  block can accept wr_char this cycle
- sel  input  5  read index from LCD driver, 0-15 line 1, 16-31 line 2
- dd_data  output  8  registered buffer[sel]
- cursor  output  5  next write position
- busy  output  1  clear sequence in progress

Behaviour:
Clock and reset:
- One clock (`clk`). Reset `rst` is asynchronous and active-high.
- Reset values: cursor=0, dd_data=FILL_CHAR, wr_ready=0, busy=1, FSM=CLEAR with clear_idx=0.
- Buffer contents are not reset directly; the CLEAR pass after reset initialises them.
- Reset asserted mid-clear or mid-transfer aborts the operation and restarts CLEAR from index 0.

FSM states:
- CLEAR: writes FILL_CHAR to address clear_idx, clear_idx+1 each cycle. After writing index 31, the next state is IDLE. Exactly 32 cycles. wr_ready=0, busy=1.
- IDLE: wr_ready=1, busy=0. A transfer occurs on any cycle with wr_valid && wr_ready. At most one character per cycle; back-to-back accepts are allowed.

Character decode on an accepted transfer:
- 8'h0C (form feed): no buffer write; cursor<=0; next state CLEAR. wr_ready drops the following cycle.
- 8'h0A (newline): cursor<=LINE_LEN if cursor<LINE_LEN, else 0. No write.
- 8'h08 (backspace): cursor<=cursor-1 mod 32 (0 wraps to 31); write FILL_CHAR at the new position in the same cycle.
- 8'h09, 8'h0B, 8'h0D-8'h1F: consumed, no effect.
- All other codes, including 8'h00-8'h07 (CG RAM glyphs) and 8'h80-8'hFF (LCD ROM glyphs):
  - write wr_char at cursor;
  - cursor<=cursor+1 mod 32 (15->16 continues onto line 2; 31->0 wraps to the top, no scroll).

Read port:
- dd_data<=buffer[sel] every clock, giving 1-cycle latency.
- If a write and a read hit the same address in the same cycle, dd_data returns the old contents (read-before-write); the new value is visible the next cycle.
- The read port is valid in every state, including CLEAR. The driver holds `sel` stable for thousands of cycles before sampling, so 1-cycle latency is sufficient.

Cursor:
- The `cursor` output is the registered value and updates the cycle after the accepting edge.

Decomposition:
- Package `lcd_pkg` holds:
  - constants CH_FF=8'h0C, CH_LF=8'h0A, CH_BS=8'h08, CH_SPACE=8'h20;
  - LCD_CHARS=32 and LCD_LINE=16;
  - FSM state enumeration {ST_CLEAR, ST_IDLE}.
- Sub-module `lcd_char_ram`: 32x8, one synchronous write port, one synchronous read port, read-before-write; infers distributed RAM.
- Top level holds the FSM, decode and cursor logic.

Test Plan:
- Reset then release -> busy=1 and wr_ready=0 for exactly 32 cycles, then wr_ready=1; sweeping sel 0-31 returns 8'h20 for every index one cycle after each sel change.
- Push "HELLO" back-to-back with wr_valid held high -> 5 accepts in 5 cycles; cursor=5; sel=0..4 reads 48,45,4C,4C,4F; sel=5 reads 20.
- From cursor=3: push 0x0A -> cursor=16; push 0x0A again -> cursor=0; push 0x08 at cursor=0 -> cursor=31 and buffer[31]=8'h20.
- Push 17 printable characters -> char 17 lands at index 16 (line 2). Push 32 more -> the last write is index 16 again after the 31->0 wrap.
- Fill the buffer, then push 0x0C -> the next cycle wr_ready=0 for 32 cycles, cursor=0, all entries read 8'h20. Pulse rst during clear cycle 10 -> the clear restarts and runs a full 32 cycles after release.
- Write 8'h41 at index 7 while sel=7 -> dd_data shows the old value on the next edge and 8'h41 one cycle after. Push 0x1B -> accepted, cursor unchanged, no buffer change.

Source files
------------

// File: rtl/lcd_text_buffer_pkg.sv
// Shared constants, FSM states and write-request type for the LCD text buffer.
package lcd_pkg;

   localparam int LCD_CHARS = 32;
   localparam int LCD_LINE  = 16;

   localparam logic [7:0] CH_FF    = 8'h0C;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_BS    = 8'h08;
   localparam logic [7:0] CH_SPACE = 8'h20;

   typedef enum logic {ST_CLEAR, ST_IDLE} lcd_state_e;

   typedef struct packed {
      logic       en;
      logic [4:0] addr;
      logic [7:0] data;
   } ram_wr_t;

   // Control codes that are swallowed without touching buffer or cursor.
   function automatic logic is_inert(input logic [7:0] c);
      return (c == 8'h09) || (c == 8'h0B) || ((c >= 8'h0D) && (c <= 8'h1F));
   endfunction

endpackage

// File: rtl/lcd_char_ram.sv
// 32x8 character store: one sync write port, one registered read port,
// read-before-write on address collision.
module lcd_char_ram
   import lcd_pkg::*;
#(
   parameter logic [7:0] FILL_CHAR = CH_SPACE
) (
   input  logic       clk,
   input  logic       rst,
   input  ram_wr_t    wr,
   input  logic [4:0] rd_addr,
   output logic [7:0] rd_data
);

   logic [7:0] mem [LCD_CHARS];

   // Array itself carries no reset so it maps onto distributed RAM.
   always_ff @(posedge clk) begin
      if (wr.en) mem[wr.addr] <= wr.data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data <= FILL_CHAR;
      else     rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/lcd_text_buffer.sv
// 32-character screen buffer feeding the HD44780 driver: host write port with
// control-code decode, wrapping cursor, and a self-clearing pass after reset/FF.
module lcd_text_buffer
   import lcd_pkg::*;
#(
   parameter int         LINE_LEN  = LCD_LINE,
   parameter logic [7:0] FILL_CHAR = CH_SPACE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_valid,
   input  logic [7:0] wr_char,
   output logic       wr_ready,
   input  logic [4:0] sel,
   output logic [7:0] dd_data,
   output logic [4:0] cursor,
   output logic       busy
);

   localparam logic [4:0] LINE2_START = 5'(LINE_LEN);
   localparam logic [4:0] LAST_IDX    = 5'(LCD_CHARS - 1);

   lcd_state_e state_q, state_d;
   logic [4:0] clear_idx_q, clear_idx_d;
   logic [4:0] cursor_q, cursor_d;
   ram_wr_t    wr;
   logic       accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_CLEAR;
         clear_idx_q <= '0;
         cursor_q    <= '0;
      end else begin
         state_q     <= state_d;
         clear_idx_q <= clear_idx_d;
         cursor_q    <= cursor_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      clear_idx_d = clear_idx_q;
      cursor_d    = cursor_q;
      wr          = '0;
      wr_ready    = 1'b0;
      busy        = 1'b0;
      accept      = 1'b0;
      unique case (state_q)
         ST_CLEAR: begin
            busy        = 1'b1;
            wr.en       = 1'b1;
            wr.addr     = clear_idx_q;
            wr.data     = FILL_CHAR;
            clear_idx_d = clear_idx_q + 5'd1;
            if (clear_idx_q == LAST_IDX) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            wr_ready = 1'b1;
            accept   = wr_valid;
            if (accept) begin
               if (wr_char == CH_FF) begin
                  cursor_d    = '0;
                  clear_idx_d = '0;
                  state_d     = ST_CLEAR;
               end else if (wr_char == CH_LF) begin
                  cursor_d = (cursor_q < LINE2_START) ? LINE2_START : 5'd0;
               end else if (wr_char == CH_BS) begin
                  // Step back first, then blank the cell we landed on.
                  cursor_d = cursor_q - 5'd1;
                  wr.en    = 1'b1;
                  wr.addr  = cursor_q - 5'd1;
                  wr.data  = FILL_CHAR;
               end else if (!is_inert(wr_char)) begin
                  wr.en    = 1'b1;
                  wr.addr  = cursor_q;
                  wr.data  = wr_char;
                  cursor_d = cursor_q + 5'd1;
               end
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   assign cursor = cursor_q;

   lcd_char_ram #(.FILL_CHAR(FILL_CHAR)) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr),
      .rd_addr (sel),
      .rd_data (dd_data)
   );

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed bench for lcd_text_buffer with a reference buffer/cursor model and
// an expected-value queue drained as the DUT produces each result.
module tb_lcd_text_buffer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_char = 8'h00;
   logic       wr_ready;
   logic [4:0] sel = 5'd0;
   logic [7:0] dd_data;
   logic [4:0] cursor;
   logic       busy;

   int errors = 0;
   int checks = 0;

   logic [7:0] model_mem [32];
   logic [4:0] model_cur;
   logic [7:0] exp_q [$];

   always #10 clk = ~clk;

   lcd_text_buffer dut (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (wr_valid),
      .wr_char  (wr_char),
      .wr_ready (wr_ready),
      .sel      (sel),
      .dd_data  (dd_data),
      .cursor   (cursor),
      .busy     (busy)
   );

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model_mem[i] = 8'h20;
   endtask

   // Reference behaviour of one accepted character.
   task automatic model_push(input logic [7:0] c);
      if (c == 8'h0C) begin
         model_cur = 5'd0;
         model_clear();
      end else if (c == 8'h0A) begin
         model_cur = (model_cur < 5'd16) ? 5'd16 : 5'd0;
      end else if (c == 8'h08) begin
         model_cur = model_cur - 5'd1;
         model_mem[model_cur] = 8'h20;
      end else if (c == 8'h09 || c == 8'h0B || (c >= 8'h0D && c <= 8'h1F)) begin
         model_cur = model_cur;
      end else begin
         model_mem[model_cur] = c;
         model_cur = model_cur + 5'd1;
      end
   endtask

   // Drive one character; valid stays high when more follow back-to-back.
   task automatic send(input logic [7:0] c, input bit last = 1'b1);
      chk("ready_before_send", {7'd0, wr_ready}, 8'd1);
      wr_valid = 1'b1;
      wr_char  = c;
      model_push(c);
      exp_q.push_back({3'd0, model_cur});
      tick();
      if (last) wr_valid = 1'b0;
      chk("cursor", {3'd0, cursor}, exp_q.pop_front());
   endtask

   task automatic rd(input int idx);
      sel = 5'(idx);
      exp_q.push_back(model_mem[idx]);
      tick();
      chk("dd_data", dd_data, exp_q.pop_front());
   endtask

   task automatic expect_clear(input string tag);
      for (int i = 0; i < 32; i++) begin
         chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
         chk({tag, "_ready"}, {7'd0, wr_ready}, 8'd0);
         tick();
      end
      chk({tag, "_done_ready"}, {7'd0, wr_ready}, 8'd1);
      chk({tag, "_done_busy"}, {7'd0, busy}, 8'd0);
   endtask

   initial begin
      model_cur = 5'd0;
      model_clear();

      // Reset state
      tick(); tick();
      chk("rst_dd", dd_data, 8'h20);
      chk("rst_cursor", {3'd0, cursor}, 8'd0);
      chk("rst_ready", {7'd0, wr_ready}, 8'd0);
      chk("rst_busy", {7'd0, busy}, 8'd1);
      rst = 1'b0;
      expect_clear("init_clear");
      for (int i = 0; i < 32; i++) rd(i);

      // HELLO back-to-back
      send(8'h48, 1'b0); send(8'h45, 1'b0); send(8'h4C, 1'b0);
      send(8'h4C, 1'b0); send(8'h4F, 1'b1);
      chk("hello_cursor", {3'd0, cursor}, 8'd5);
      for (int i = 0; i <= 5; i++) rd(i);

      // Backspace down to 3, then newline and wrap cases
      send(8'h08); send(8'h08);
      chk("bs_cursor3", {3'd0, cursor}, 8'd3);
      send(8'h0A);
      chk("lf_to_16", {3'd0, cursor}, 8'd16);
      send(8'h0A);
      chk("lf_to_0", {3'd0, cursor}, 8'd0);
      send(8'h08);
      chk("bs_wrap31", {3'd0, cursor}, 8'd31);
      rd(31); rd(3); rd(4);

      // One char at 31 wraps to 0; then 17 chars, then 32 more incl. glyph codes
      send(8'h5A);
      chk("wrap_to_0", {3'd0, cursor}, 8'd0);
      for (int i = 0; i < 17; i++) send(8'h61 + 8'(i), (i == 16));
      chk("line2_cursor", {3'd0, cursor}, 8'd17);
      rd(16); rd(15);
      for (int i = 0; i < 32; i++) begin
         logic [7:0] c;
         c = (i == 5) ? 8'h03 : (i == 9) ? 8'h85 : 8'h41 + 8'(i % 26);
         send(c, (i == 31));
      end
      chk("wrap_cursor", {3'd0, cursor}, 8'd17);
      for (int i = 0; i < 32; i++) rd(i);

      // Form feed clears; then rst pulse during clear cycle 10
      send(8'h0C);
      chk("ff_ready_drop", {7'd0, wr_ready}, 8'd0);
      chk("ff_cursor", {3'd0, cursor}, 8'd0);
      expect_clear("ff_clear");
      for (int i = 0; i < 32; i++) rd(i);
      send(8'h4B);
      send(8'h0C);
      for (int i = 0; i < 10; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_cur = 5'd0;
      model_clear();
      expect_clear("rst_mid_clear");
      rd(0); rd(10); rd(31);

      // Read-before-write at index 7
      for (int i = 0; i < 7; i++) send(8'h78, (i == 6));
      sel = 5'd7;
      tick();
      exp_q.push_back(model_mem[7]);
      wr_valid = 1'b1;
      wr_char  = 8'h41;
      model_push(8'h41);
      tick();
      wr_valid = 1'b0;
      chk("rbw_old", dd_data, exp_q.pop_front());
      exp_q.push_back(model_mem[7]);
      tick();
      chk("rbw_new", dd_data, exp_q.pop_front());

      // Inert control code
      send(8'h1B);
      chk("inert_cursor", {3'd0, cursor}, 8'd8);
      for (int i = 0; i < 10; i++) rd(i);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
